vga_sync_gen: RTL
=================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 Parameter SYNC_POL, default 0, sync level when asserted (0 = active-low).
REQ-010 clk  input  1  system clock; all state changes on its rising edge.
REQ-011 reset  input  1  synchronous, active-high reset.
REQ-012 pix_en  input  1  pixel tick from the upstream divider; one clk wide; all timing advances only when it is high.
REQ-013 hsync  output  1  horizontal sync, registered.
REQ-014 vsync  output  1  vertical sync, registered.
REQ-015 video_on  output  1  high while the current position is in the visible region, registered.
REQ-016 x  output  10  current horizontal count (0..H_TOTAL-1).
REQ-017 y  output  10  current vertical count (0..V_TOTAL-1).
REQ-018 line_end  output  1  one-clk pulse on the tick that wraps x.
REQ-019 frame_end  output  1  one-clk pulse on the tick that wraps both x and y.

Function
REQ-020 H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK and V_TOTAL = the vertical equivalent; both totals SHALL be ≤1024. Other settings are unsupported.
REQ-021 x increments on each clk where pix_en=1. On such a tick at x=H_TOTAL-1, it wraps to 0.
REQ-022 y increments only on a tick where x wraps. On that tick at y=V_TOTAL-1, it wraps to 0.
REQ-023 With pix_en=0, x, y, hsync, vsync and video_on hold their values, and line_end and frame_end are 0.
REQ-024 The horizontal FSM states are H_ACT (x<H_ACTIVE), H_FP, H_SYNC and H_BP.
  - H_ACT→H_FP→H_SYNC→H_BP→H_ACT.
  - Each transition occurs on the pix_en tick that crosses the phase boundary.
REQ-025 The vertical FSM states are V_ACT, V_FP, V_SYNC and V_BP, with the same ordering. It advances only on x-wrap ticks.
REQ-026 hsync = SYNC_POL while x ∈ [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], else ~SYNC_POL. Default: x 656..751.
REQ-027 vsync = SYNC_POL while y ∈ [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], else ~SYNC_POL. Default: y 490..491.
REQ-028 video_on = 1 iff x<H_ACTIVE and y<V_ACTIVE.
REQ-029 All outputs SHALL be registered with zero latency relative to x/y: hsync, vsync and video_on always describe the x/y value presented in the same cycle.
REQ-030 line_end = 1 for exactly the clk following the pix_en tick at x=H_TOTAL-1, i.e. the cycle in which x first reads 0.
REQ-031 frame_end asserts together with line_end only when y also wrapped, i.e. when x=0 and y=0 first appear.
REQ-032 pix_en held high continuously SHALL advance x every clk with no skipped or repeated counts.

Reset
REQ-033 reset has priority over pix_en.
REQ-034 On the edge where reset=1: x=0, y=0, both FSMs enter the ACT state, hsync=~SYNC_POL, vsync=~SYNC_POL, video_on=1, line_end=0, frame_end=0.
REQ-035 Reset mid-frame (any x/y) SHALL produce the REQ-034 state on the next edge and resume counting from (0,0) on the first pix_en tick after release.

Verification
REQ-036 Reset, then pix_en=1 every clk → hsync=0 for exactly 96 consecutive clks (x 656..751); line_end pulses when x returns to 0 after 799; the period is 800 clks.
REQ-037 Continuous pix_en → frame_end pulses every 420000 clks; vsync=0 for exactly 1600 clks (y 490..491).
REQ-038 pix_en high every 4th clk → outputs constant between ticks; hsync low for 384 clks; line_end width 1 clk, every 3200 clks.
REQ-039 Boundaries, continuous pix_en:
  - (639,0)→(640,0): video_on 1→0.
  - (799,479)→(0,480): video_on stays 0.
  - (799,524)→(0,0): video_on=1, line_end=1 and frame_end=1 in the same clk.
REQ-040 reset asserted for one clk at x=700, y=491 with pix_en=1 → next clk: x=0, y=0, hsync=1, vsync=1, video_on=1, no pulses.
REQ-041 SYNC_POL=1, continuous pix_en → hsync=1 only for x 656..751 and vsync=1 only for y 490..491; reset value of both is 0.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters with phase FSMs producing sync, blanking and wrap pulses.
// Latency: all outputs registered together with x/y, so they always describe the presented position.
// Backpressure: none; timing advances only on pix_en ticks and holds otherwise.
module vga_sync_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FRONT  = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FRONT  = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_end,
    output logic       frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Last count of each phase; a tick at these values crosses into the next phase.
    localparam logic [9:0] H_ACT_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_FP_LAST   = 10'(H_ACTIVE + H_FRONT - 1);
    localparam logic [9:0] H_SYNC_LAST = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_FP_LAST   = 10'(V_ACTIVE + V_FRONT - 1);
    localparam logic [9:0] V_SYNC_LAST = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {H_ACT, H_FP, H_SYN, H_BP} h_state_t;
    typedef enum logic [1:0] {V_ACT, V_FP, V_SYN, V_BP} v_state_t;

    h_state_t   h_state, h_next;
    v_state_t   v_state, v_next;
    logic [9:0] x_next, y_next;
    logic       x_wrap, y_wrap;

    // Counter next values: x advances per tick, y only when x wraps.
    always_comb begin
        x_wrap = pix_en && (x == H_LAST);
        y_wrap = x_wrap && (y == V_LAST);
        x_next = x;
        y_next = y;
        if (pix_en) begin
            x_next = x_wrap ? 10'd0 : x + 10'd1;
        end
        if (x_wrap) begin
            y_next = y_wrap ? 10'd0 : y + 10'd1;
        end
    end

    // Horizontal phase FSM: moves on the tick leaving the last count of a phase.
    always_comb begin
        h_next = h_state;
        if (pix_en) begin
            case (h_state)
                H_ACT:   if (x == H_ACT_LAST)  h_next = H_FP;
                H_FP:    if (x == H_FP_LAST)   h_next = H_SYN;
                H_SYN:   if (x == H_SYNC_LAST) h_next = H_BP;
                H_BP:    if (x == H_LAST)      h_next = H_ACT;
                default:                       h_next = H_ACT;
            endcase
        end
    end

    // Vertical phase FSM: same sequence, stepped only on line wraps.
    always_comb begin
        v_next = v_state;
        if (x_wrap) begin
            case (v_state)
                V_ACT:   if (y == V_ACT_LAST)  v_next = V_FP;
                V_FP:    if (y == V_FP_LAST)   v_next = V_SYN;
                V_SYN:   if (y == V_SYNC_LAST) v_next = V_BP;
                V_BP:    if (y == V_LAST)      v_next = V_ACT;
                default:                       v_next = V_ACT;
            endcase
        end
    end

    // State and output registers; outputs decode the next phase so they line up with x/y.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_state   <= H_ACT;
            v_state   <= V_ACT;
            x         <= 10'd0;
            y         <= 10'd0;
            hsync     <= ~SYNC_POL;
            vsync     <= ~SYNC_POL;
            video_on  <= 1'b1;
            line_end  <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            h_state   <= h_next;
            v_state   <= v_next;
            x         <= x_next;
            y         <= y_next;
            hsync     <= (h_next == H_SYN) ? SYNC_POL : ~SYNC_POL;
            vsync     <= (v_next == V_SYN) ? SYNC_POL : ~SYNC_POL;
            video_on  <= (h_next == H_ACT) && (v_next == V_ACT);
            line_end  <= x_wrap;
            frame_end <= y_wrap;
        end
    end

endmodule
